// File: rtl/rkob_ptp_pkg.sv
// Shared constants for the PTP timestamp FIFO: word width, RAM depth and
// the almost-full threshold used by the controller and RAM defaults.
package rkob_ptp_pkg;

   localparam int PTP_DATA_WIDTH = 52;
   localparam int PTP_ADDR_WIDTH = 12;
   localparam int PTP_PTR_WIDTH  = PTP_ADDR_WIDTH + 1;
   localparam int PTP_AF_LEVEL   = 4032;

endpackage

// File: rtl/rkob_ptp_ram.sv
// Single-clock simple dual-port RAM: synchronous write, registered read
// address, read data valid the cycle after the address is presented.
module rkob_ptp_ram
   import rkob_ptp_pkg::*;
#(
   parameter int DATA_WIDTH = PTP_DATA_WIDTH,
   parameter int ADDR_WIDTH = PTP_ADDR_WIDTH,
   parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [ADDR_WIDTH-1:0] rd_addr_q;

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      rd_addr_q <= rd_addr;
   end

   assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/rkob_ptp_fifo_ctrl.sv
// Pointer/flag controller that turns rkob_ptp_ram into a synchronous FIFO:
// RAM write/read addressing, registered occupancy flags, sticky error flags.
module rkob_ptp_fifo_ctrl
   import rkob_ptp_pkg::*;
#(
   parameter int DATA_WIDTH = PTP_DATA_WIDTH,
   parameter int ADDR_WIDTH = PTP_ADDR_WIDTH,
   parameter int AF_LEVEL   = PTP_AF_LEVEL
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW-1:0] wr_ptr_nx, rd_ptr_nx, count_nx;
   logic          push_ok, pop_ok;
   logic          full_nx, empty_nx, af_nx;

   // Accept decisions use the registered flags only, so a pop never frees
   // room for a same-cycle push and a push never feeds a same-cycle pop.
   always_comb begin
      push_ok   = push & ~full  & ~clr;
      pop_ok    = pop  & ~empty & ~clr;
      wr_ptr_nx = wr_ptr + PW'(push_ok);
      rd_ptr_nx = rd_ptr + PW'(pop_ok);
      if (clr) begin
         wr_ptr_nx = '0;
         rd_ptr_nx = '0;
      end
      count_nx = wr_ptr_nx - rd_ptr_nx;
      empty_nx = (wr_ptr_nx == rd_ptr_nx);
      full_nx  = (wr_ptr_nx[ADDR_WIDTH-1:0] == rd_ptr_nx[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_nx[ADDR_WIDTH] != rd_ptr_nx[ADDR_WIDTH]);
      af_nx    = (count_nx >= AF_THRESH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         pop_valid   <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nx;
         rd_ptr      <= rd_ptr_nx;
         count       <= count_nx;
         full        <= full_nx;
         empty       <= empty_nx;
         almost_full <= af_nx;
         pop_valid   <= pop_ok;
         if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            overflow  <= overflow  | (push & full);
            underflow <= underflow | (pop & empty);
         end
      end
   end

   // The RAM always latches the head address, so a pop's data appears next cycle.
   assign ram_we      = push_ok;
   assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_wr_data = push_data;
   assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
   assign pop_data    = ram_rd_data;

endmodule

// File: tb/tb_rkob_ptp_fifo_ctrl.sv
// Directed bench for rkob_ptp_fifo_ctrl with the RAM model at depth 8,
// almost-full at 6; popped data is checked against an expected queue.
module tb_rkob_ptp_fifo_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int AF    = 6;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          push = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          pop = 1'b0;
   logic [DW-1:0] pop_data;
   logic          pop_valid, full, empty, almost_full, overflow, underflow;
   logic [AW:0]   count;
   logic          ram_we;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [DW-1:0] ram_wr_data, ram_rd_data;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] model_q[$];

   always #5 clk = ~clk;

   rkob_ptp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .push_data(push_data),
      .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .count(count),
      .overflow(overflow), .underflow(underflow), .ram_we(ram_we),
      .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
   );

   rkob_ptp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) u_ram (
      .clk(clk), .we(ram_we), .wr_addr(ram_wr_addr), .wr_data(ram_wr_data),
      .rd_addr(ram_rd_addr), .rd_data(ram_rd_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_flags(input string name, input int cnt, input logic f, input logic e,
                            input logic af, input logic ov, input logic un);
      chk({name, " count"}, 64'(count), 64'(cnt));
      chk({name, " full"}, 64'(full), 64'(f));
      chk({name, " empty"}, 64'(empty), 64'(e));
      chk({name, " almost_full"}, 64'(almost_full), 64'(af));
      chk({name, " overflow"}, 64'(overflow), 64'(ov));
      chk({name, " underflow"}, 64'(underflow), 64'(un));
   endtask

   // One clock of stimulus, entered and left at posedge+1.
   task automatic step(input logic p, input logic [DW-1:0] d, input logic q, input logic c);
      logic p_ok, q_ok;
      p_ok = p && !c && (model_q.size() < DEPTH);
      q_ok = q && !c && (model_q.size() > 0);
      push = p; push_data = d; pop = q; clr = c;
      #1;
      chk("ram_we", 64'(ram_we), 64'(p_ok));
      if (p_ok) chk("ram_wr_data", 64'(ram_wr_data), 64'(d));
      if (q_ok) exp_q.push_back(model_q.pop_front());
      if (p_ok) model_q.push_back(d);
      if (c) model_q.delete();
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; clr = 1'b0;
   endtask

   // Monitor: every presented word must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && pop_valid) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got %0h expected none at %0t", pop_data, $time);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (pop_data !== e) begin
               n_fail++;
               $display("FAIL pop_data: got %0h expected %0h at %0t", pop_data, e, $time);
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk_flags("reset", 0, 0, 1, 0, 0, 0);
      chk("reset pop_valid", 64'(pop_valid), 0);
      chk("reset ram_we", 64'(ram_we), 0);
      chk("reset ram_wr_addr", 64'(ram_wr_addr), 0);
      chk("reset ram_rd_addr", 64'(ram_rd_addr), 0);

      // Fill 1..8, then one rejected push
      for (int i = 1; i <= 8; i++) begin
         step(1, DW'(i), 0, 0);
         chk_flags("fill", i, i == 8, 0, i >= 6, 0, 0);
      end
      step(1, 16'h0009, 0, 0);
      chk_flags("push_full", 8, 1, 0, 1, 1, 0);

      // Drain back-to-back, then one rejected pop
      for (int i = 0; i < 8; i++) begin
         step(0, '0, 1, 0);
         chk("drain pop_valid", 64'(pop_valid), 1);
         chk("drain count", 64'(count), 64'(7 - i));
      end
      step(0, '0, 0, 0);
      chk_flags("drained", 0, 0, 1, 0, 1, 0);
      step(0, '0, 1, 0);
      chk_flags("pop_empty", 0, 0, 1, 0, 1, 1);
      chk("pop_empty pop_valid", 64'(pop_valid), 0);
      step(0, '0, 0, 1);
      chk_flags("clr1", 0, 0, 1, 0, 0, 0);

      // Simultaneous push/pop with 3 stored
      for (int i = 0; i < 3; i++) step(1, DW'(16'h11 + i), 0, 0);
      step(1, 16'h0014, 1, 0);
      chk_flags("pushpop3", 3, 0, 0, 0, 0, 0);
      step(1, 16'h0015, 1, 0);
      chk_flags("pushpop3b", 3, 0, 0, 0, 0, 0);
      repeat (3) step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      chk_flags("drain3", 0, 0, 1, 0, 0, 0);

      // Simultaneous push/pop when full
      for (int i = 0; i < 8; i++) step(1, DW'(16'h20 + i), 0, 0);
      step(1, 16'h0099, 1, 0);
      chk_flags("pushpop_full", 7, 0, 0, 1, 1, 0);
      repeat (7) step(0, '0, 1, 0);
      step(0, '0, 0, 1);
      chk_flags("clr2", 0, 0, 1, 0, 0, 0);

      // Simultaneous push/pop when empty
      step(1, 16'h0055, 1, 0);
      chk_flags("pushpop_empty", 1, 0, 0, 0, 0, 1);
      chk("pushpop_empty pop_valid", 64'(pop_valid), 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 1);
      chk_flags("clr3", 0, 0, 1, 0, 0, 0);

      // 20 pushes and 20 pops alternating: addresses wrap 2.5 times
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) step(1, DW'(16'h100 + i / 2), 0, 0);
         else            step(0, '0, 1, 0);
      end
      step(0, '0, 0, 0);
      chk_flags("wrap", 0, 0, 1, 0, 0, 0);
      chk("wrap ram_wr_addr", 64'(ram_wr_addr), 4);
      chk("wrap ram_rd_addr", 64'(ram_rd_addr), 4);

      // clr with 5 stored plus a pending error, push and pop asserted
      step(0, '0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, DW'(16'h200 + i), 0, 0);
      chk_flags("five", 5, 0, 0, 0, 0, 1);
      step(1, 16'h02ff, 1, 1);
      chk_flags("clr_busy", 0, 0, 1, 0, 0, 0);
      chk("clr_busy pop_valid", 64'(pop_valid), 0);
      chk("clr_busy ram_rd_addr", 64'(ram_rd_addr), 0);

      // Asynchronous reset with a pop in flight
      for (int i = 0; i < 3; i++) step(1, DW'(16'h300 + i), 0, 0);
      pop = 1'b1;
      @(posedge clk); #2;
      pop = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_flags("async_rst", 0, 0, 1, 0, 0, 0);
      chk("async_rst pop_valid", 64'(pop_valid), 0);
      model_q.delete();
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      step(1, 16'h0400, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      chk_flags("post_rst", 0, 0, 1, 0, 0, 0);

      repeat (2) @(posedge clk);
      chk("exp_q drained", 64'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rkob_ptp_fifo_ctrl.md
# rkob_ptp_fifo_ctrl

Pointer/flag controller that turns the team's single-clock simple dual-port RAM (`rkob_ptp_ram`: synchronous write, registered read address, read data valid the cycle after the address is presented) into a synchronous FIFO. The block sits beside the RAM in the PTP timestamp path. It accepts push/pop requests, generates the RAM write enable and both addresses, and reports occupancy, full/empty, almost-full and sticky error flags.

## Interface
Parameters:
- `DATA_WIDTH`, default 52: word width, passed through to the RAM.
- `ADDR_WIDTH`, default 12: RAM address width. Depth is 2^ADDR_WIDTH and must match the RAM `MEM_DEPTH`.
- `AF_LEVEL`, default 4032: `almost_full` asserts when `count >= AF_LEVEL`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clr`  in  1: synchronous flush.
- `push`  in  1: write request.
- `push_data`  in  DATA_WIDTH: word to write.
- `pop`  in  1: read request.
- `pop_data`  out  DATA_WIDTH: connected straight from `ram_rd_data`.
- `pop_valid`  out  1: `pop_data` holds the popped word this cycle.
- `full`, `empty`, `almost_full`  out  1 each: occupancy flags.
- `count`  out  ADDR_WIDTH+1: number of stored words.
- `overflow`, `underflow`  out  1 each: sticky error flags.
- `ram_we`  out  1: RAM write enable.
- `ram_wr_addr`, `ram_rd_addr`  out  ADDR_WIDTH: RAM write and read addresses.
- `ram_wr_data`  out  DATA_WIDTH: RAM write data.
- `ram_rd_data`  in  DATA_WIDTH: RAM read data.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each ADDR_WIDTH+1 bits. The MSB is the wrap bit, and the RAM addresses are the low ADDR_WIDTH bits.
  - Empty: the two pointers are equal.
  - Full: the low bits are equal and the MSBs differ.
  - `count` = `wr_ptr` - `rd_ptr`, computed modulo 2^(ADDR_WIDTH+1).
- Accepted push: `push & ~full & ~clr`. It drives `ram_we`=1 with `ram_wr_addr`=`wr_ptr[ADDR_WIDTH-1:0]` and `ram_wr_data`=`push_data`, all combinational. `wr_ptr` increments at the edge.
- Accepted pop: `pop & ~empty & ~clr`. The read address is the current `rd_ptr` low bits. `rd_ptr` increments at the edge, and `pop_valid` is registered to 1.
- `ram_rd_addr` = `rd_ptr[ADDR_WIDTH-1:0]`, combinational, so the RAM always latches the current head address.
- Flags `full`, `empty`, `almost_full` and `count` are registered. They reflect the pointers after each edge.
- Simultaneous events:
  - Push while full is rejected even when a pop is accepted in the same cycle. This avoids overwriting the head slot that is being read.
  - Pop while empty is rejected even when a push is accepted in the same cycle. There is no write-through.
  - Push and pop both accepted: `count` is unchanged, and both pointers advance.
- Errors:
  - A rejected push (not caused by `clr`) sets `overflow`.
  - A rejected pop (not caused by `clr`) sets `underflow`.
  - Both flags hold until `clr` or reset.
- `clr` has priority over everything in its cycle:
  - Both pointers go to 0, and `overflow`/`underflow` are cleared.
  - `pop_valid` is 0 in the next cycle.
  - `push` and `pop` are ignored and raise no error.
  - RAM contents are not erased.
- Wrap-around: the pointers roll over naturally at 2^(ADDR_WIDTH+1), and the addresses roll over at 2^ADDR_WIDTH.

## Timing
- Reset values:
  - Pointers, `count`, `full`, `almost_full`, `overflow`, `underflow` and `pop_valid` are all 0.
  - `empty` is 1.
  - `ram_we` is 0 because it is gated by `push`.
- Reset asserted mid-operation clears all state immediately and asynchronously. A `pop_valid` that was pending is lost.
- Push to flag latency: one edge. The first push raises `empty`→0 in the following cycle.
- Pop latency: request in cycle N gives `pop_valid`=1 and data in cycle N+1.
  - The consumer must sample in N+1, because a push in N+1 may rewrite the freed slot at the N+2 edge.
- Back-to-back pops give one word per cycle.
- Full throughput: one push and one pop per cycle, sustained.

## Structure
- Shared package `rkob_ptp_pkg` holds:
  - `PTP_DATA_WIDTH`=52, `PTP_ADDR_WIDTH`=12, `PTP_AF_LEVEL`.
  - A pointer-width helper constant `PTP_PTR_WIDTH`=`PTP_ADDR_WIDTH`+1.
- No sub-module inside the controller. The top level instantiates `rkob_ptp_fifo_ctrl` and `rkob_ptp_ram` side by side, wiring `ram_*` to the RAM ports.

## Test plan
The bench uses `ADDR_WIDTH`=3 (depth 8), `AF_LEVEL`=6 and the real RAM model.
- Reset, then idle: `empty`=1, `count`=0, `ram_we`=0 and all other outputs 0. Asserting `rst_n` low asynchronously between edges clears a non-empty FIFO at once.
- Push 0x1..0x8 on consecutive cycles: `almost_full` rises after the 6th push and `full` after the 8th, with `count`=8. A 9th push sets `overflow` and leaves `count`=8.
- From full, pop 8 times back-to-back: `pop_valid` asserts in cycles 1..8 after the first pop with data 0x1..0x8 in order. `empty`=1 afterwards. An extra pop sets `underflow`.
- Simultaneous push and pop:
  - With 3 words stored: `count` stays 3 and data order is preserved.
  - When full: the pop is accepted, the push is rejected, and `overflow`=1.
  - When empty: the push is accepted, the pop is rejected, and `underflow`=1.
- Run 20 pushes and pops interleaved at 50% through multiple wraps: output sequence equals input sequence and the pointers wrap correctly.
- `clr` asserted together with push and pop while holding 5 words: next cycle `count`=0, `empty`=1, `pop_valid`=0, and both error flags are 0.
